// File: rtl/cache_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_arbiter_pkg
// Description : Shared cache definitions. Holds the default line/address
//               widths and derived line constants, the arbiter state type
//               and the memory-port grant-owner encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package cache_mem_arbiter_pkg;

  // Cache line geometry defaults.
  localparam int unsigned c_ADDR_W       = 32;
  localparam int unsigned c_LINE_W       = 128;
  localparam int unsigned c_LINE_BYTES   = c_LINE_W / 8;
  localparam int unsigned c_LINE_OFFS_W  = $clog2(c_LINE_BYTES);

  // Memory-port arbiter states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } type_arb_state_e;

  // Which cache owns (or last owned) the memory port.
  typedef enum logic {
    OWNER_ICACHE = 1'b0,
    OWNER_DCACHE = 1'b1
  } type_arb_owner_e;

endpackage : cache_mem_arbiter_pkg
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_arbiter
// Description : Shares the single data-memory port between the icache
//               (line refills) and the write-back dcache (refills and
//               writebacks). One whole line transaction is granted at a
//               time; the memory ack is routed back to the granted cache.
//               Tie policy: round-robin when ARB_ROUND_ROBIN_EN is defined,
//               otherwise fixed dcache priority.
// Ports       : clk_i, rst_i (async, active high)
//               icache_req_i/addr_i -> icache_ack_o/rdata_o
//               dcache_req_i/wr_i/addr_i/wdata_i -> dcache_ack_o/rdata_o
//               mem_req_o/wr_o/addr_o/wdata_o <- mem_ack_i/rdata_i
//               busy_o : a grant is active
// Macros      : ARB_ROUND_ROBIN_EN
// Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = c_ADDR_W,
  parameter int unsigned LINE_W = c_LINE_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              icache_req_i,
  input  logic [ADDR_W-1:0] icache_addr_i,
  output logic              icache_ack_o,
  output logic [LINE_W-1:0] icache_rdata_o,
  input  logic              dcache_req_i,
  input  logic              dcache_wr_i,
  input  logic [ADDR_W-1:0] dcache_addr_i,
  input  logic [LINE_W-1:0] dcache_wdata_i,
  output logic              dcache_ack_o,
  output logic [LINE_W-1:0] dcache_rdata_o,
  output logic              mem_req_o,
  output logic              mem_wr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  type_arb_state_e r_state;
  type_arb_state_e w_state_next;
  logic            w_tie_to_dcache;

`ifdef ARB_ROUND_ROBIN_EN
  type_arb_owner_e r_last_gnt;

  // On a tie, serve whichever cache was not served last.
  assign w_tie_to_dcache = (r_last_gnt == OWNER_ICACHE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last_gnt <= OWNER_ICACHE;
    end else if (r_state == IDLE) begin
      if (w_state_next == GNT_I) begin
        r_last_gnt <= OWNER_ICACHE;
      end else if (w_state_next == GNT_D) begin
        r_last_gnt <= OWNER_DCACHE;
      end
    end
  end
`else
  // Fixed priority: dcache wins every tie.
  assign w_tie_to_dcache = 1'b1;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Memory-side signals are muxed straight from the owner so the
  // requester's held address/data reach memory without a register stage.
  always_comb begin
    w_state_next = r_state;
    mem_req_o    = 1'b0;
    mem_wr_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    icache_ack_o = 1'b0;
    dcache_ack_o = 1'b0;

    case (r_state)
      IDLE: begin
        // mem_ack_i is deliberately ignored here.
        if (icache_req_i && dcache_req_i) begin
          w_state_next = w_tie_to_dcache ? GNT_D : GNT_I;
        end else if (icache_req_i) begin
          w_state_next = GNT_I;
        end else if (dcache_req_i) begin
          w_state_next = GNT_D;
        end
      end
      GNT_I: begin
        mem_req_o  = 1'b1;
        mem_addr_o = icache_addr_i;
        if (mem_ack_i) begin
          icache_ack_o = 1'b1;
          w_state_next = IDLE;
        end
      end
      GNT_D: begin
        mem_req_o   = 1'b1;
        mem_wr_o    = dcache_wr_i;
        mem_addr_o  = dcache_addr_i;
        mem_wdata_o = dcache_wdata_i;
        if (mem_ack_i) begin
          dcache_ack_o = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Read data goes to both caches; only the acks qualify it.
  assign icache_rdata_o = mem_rdata_i;
  assign dcache_rdata_o = mem_rdata_i;
  assign busy_o         = (r_state != IDLE);

endmodule : cache_mem_arbiter
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_mem_arbiter
// Description : Self-checking bench for cache_mem_arbiter: reset state,
//               a table of single-cycle vectors, tie-break rounds, reset
//               mid-transaction, and a randomized run against a
//               transaction-level reference model.
// Ports       : none
// Macros      : ARB_ROUND_ROBIN_EN (selects the expected tie policy)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned LINE_W  = 128;
  localparam logic [ADDR_W-1:0] I_ADDR  = 32'h0000_1000;
  localparam logic [ADDR_W-1:0] D_ADDR  = 32'h8000_0040;
  localparam logic [LINE_W-1:0] D_WDATA = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
  localparam logic [LINE_W-1:0] RD_A5   = {16{8'hA5}};

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              icache_req_i;
  logic [ADDR_W-1:0] icache_addr_i;
  logic              icache_ack_o;
  logic [LINE_W-1:0] icache_rdata_o;
  logic              dcache_req_i;
  logic              dcache_wr_i;
  logic [ADDR_W-1:0] dcache_addr_i;
  logic [LINE_W-1:0] dcache_wdata_i;
  logic              dcache_ack_o;
  logic [LINE_W-1:0] dcache_rdata_o;
  logic              mem_req_o;
  logic              mem_wr_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [LINE_W-1:0] mem_rdata_i;
  logic              busy_o;

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .icache_req_i   (icache_req_i),
    .icache_addr_i  (icache_addr_i),
    .icache_ack_o   (icache_ack_o),
    .icache_rdata_o (icache_rdata_o),
    .dcache_req_i   (dcache_req_i),
    .dcache_wr_i    (dcache_wr_i),
    .dcache_addr_i  (dcache_addr_i),
    .dcache_wdata_i (dcache_wdata_i),
    .dcache_ack_o   (dcache_ack_o),
    .dcache_rdata_o (dcache_rdata_o),
    .mem_req_o      (mem_req_o),
    .mem_wr_o       (mem_wr_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_ack_i      (mem_ack_i),
    .mem_rdata_i    (mem_rdata_i),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int last_d   = 0;  // model: 1 when dcache was served last

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Single-cycle vector: inputs plus expected owner (0 none, 1 I, 2 D) and acks.
  typedef struct {
    logic     ireq, dreq, dwr, mack;
    int       own;
    logic     iack, dack;
  } vec_t;

  function automatic vec_t mk(logic ir, logic dr, logic dw, logic ma, int own, logic ia, logic da);
    vec_t v;
    v.ireq = ir; v.dreq = dr; v.dwr = dw; v.mack = ma;
    v.own  = own; v.iack = ia; v.dack = da;
    return v;
  endfunction

  // Wait for a grant, ack it one cycle later, then drop the owner's req.
  task automatic serve_one(output int who);
    who = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk_i);
      if (mem_req_o) break;
      tick();
    end
    if (!mem_req_o) begin
      check("grant_timeout", {127'd0, mem_req_o}, 128'd1);
      tick();
      return;
    end
    who = (mem_addr_o == D_ADDR) ? 2 : 1;
    check("grant_wr", {127'd0, mem_wr_o}, {127'd0, (who == 2) ? dcache_wr_i : 1'b0});
    tick();
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    check("serve_iack", {127'd0, icache_ack_o}, {127'd0, who == 1});
    check("serve_dack", {127'd0, dcache_ack_o}, {127'd0, who == 2});
    tick();
    mem_ack_i = 1'b0;
    if (who == 1) icache_req_i = 1'b0;
    else          dcache_req_i = 1'b0;
  endtask

  task automatic single(input int who);
    int got;
    if (who == 1) begin
      icache_req_i = 1'b1; icache_addr_i = I_ADDR;
    end else begin
      dcache_req_i = 1'b1; dcache_wr_i = 1'b0; dcache_addr_i = D_ADDR;
    end
    serve_one(got);
    check("single_owner", got, who);
    last_d = (who == 2) ? 1 : 0;
  endtask

  task automatic tie_round(input int pre);
    int w1, w2, exp_w;
    if (pre != 0) single(pre);
`ifdef ARB_ROUND_ROBIN_EN
    exp_w = (last_d != 0) ? 1 : 2;
`else
    exp_w = 2;
`endif
    icache_req_i = 1'b1; icache_addr_i = I_ADDR;
    dcache_req_i = 1'b1; dcache_wr_i = 1'b0; dcache_addr_i = D_ADDR;
    serve_one(w1);
    check("tie_winner", w1, exp_w);
    serve_one(w2);
    check("tie_loser", w2, 3 - exp_w);
    last_d = (exp_w == 1) ? 1 : 0;
  endtask

  vec_t vecs[12];
  int   pres[4] = '{2, 0, 1, 2};

  initial begin
    int   m_own, tie_own;
    logic i_cool, d_cool, i_done, d_done;
    logic [ADDR_W-1:0] e_addr;
    logic [LINE_W-1:0] e_wdata;

    rst_i = 1'b1;
    icache_req_i = 0; icache_addr_i = '0;
    dcache_req_i = 0; dcache_wr_i = 0; dcache_addr_i = '0; dcache_wdata_i = '0;
    mem_ack_i = 0; mem_rdata_i = '0;

    // Reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_busy",   {127'd0, busy_o},       128'd0);
    check("rst_memreq", {127'd0, mem_req_o},    128'd0);
    check("rst_iack",   {127'd0, icache_ack_o}, 128'd0);
    check("rst_dack",   {127'd0, dcache_ack_o}, 128'd0);
    check("rst_irdata", icache_rdata_o,         128'd0);
    tick();
    rst_i = 1'b0;
    last_d = 0;

    // First tie after reset: dcache wins under either policy.
    tie_round(0);

    // Table-driven single-cycle vectors
    vecs[0]  = mk(0,0,0,0, 0, 0,0);
    vecs[1]  = mk(1,0,0,0, 0, 0,0);
    vecs[2]  = mk(1,0,0,0, 1, 0,0);
    vecs[3]  = mk(1,0,0,0, 1, 0,0);
    vecs[4]  = mk(1,0,0,1, 1, 1,0);
    vecs[5]  = mk(0,0,0,0, 0, 0,0);
    vecs[6]  = mk(0,0,0,1, 0, 0,0);
    vecs[7]  = mk(0,0,0,0, 0, 0,0);
    vecs[8]  = mk(0,1,1,0, 0, 0,0);
    vecs[9]  = mk(0,1,1,0, 2, 0,0);
    vecs[10] = mk(0,1,1,1, 2, 0,1);
    vecs[11] = mk(0,0,0,0, 0, 0,0);
    icache_addr_i = I_ADDR; dcache_addr_i = D_ADDR; dcache_wdata_i = D_WDATA;
    mem_rdata_i = RD_A5;
    for (int k = 0; k < 12; k++) begin
      icache_req_i = vecs[k].ireq; dcache_req_i = vecs[k].dreq;
      dcache_wr_i  = vecs[k].dwr;  mem_ack_i    = vecs[k].mack;
      @(negedge clk_i);
      check("vec_memreq", {127'd0, mem_req_o}, {127'd0, vecs[k].own != 0});
      check("vec_busy",   {127'd0, busy_o},    {127'd0, vecs[k].own != 0});
      check("vec_memwr",  {127'd0, mem_wr_o},  {127'd0, (vecs[k].own == 2) && vecs[k].dwr});
      check("vec_addr",   {96'd0, mem_addr_o},
            {96'd0, (vecs[k].own == 1) ? I_ADDR : (vecs[k].own == 2) ? D_ADDR : 32'd0});
      check("vec_wdata",  mem_wdata_o, (vecs[k].own == 2) ? D_WDATA : 128'd0);
      check("vec_iack",   {127'd0, icache_ack_o}, {127'd0, vecs[k].iack});
      check("vec_dack",   {127'd0, dcache_ack_o}, {127'd0, vecs[k].dack});
      if (vecs[k].iack || vecs[k].dack) begin
        check("vec_irdata", icache_rdata_o, RD_A5);
        check("vec_drdata", dcache_rdata_o, RD_A5);
      end
      tick();
    end
    mem_ack_i = 1'b0;
    last_d = 1;

    // Tie rounds with varying history
    for (int r = 0; r < 4; r++) tie_round(pres[r]);

    // Reset two cycles into a dcache writeback
    dcache_req_i = 1'b1; dcache_wr_i = 1'b1; dcache_addr_i = D_ADDR; dcache_wdata_i = D_WDATA;
    tick();
    @(negedge clk_i);
    check("wb_memreq", {127'd0, mem_req_o}, 128'd1);
    check("wb_memwr",  {127'd0, mem_wr_o},  128'd1);
    check("wb_wdata",  mem_wdata_o, D_WDATA);
    tick();
    tick();
    rst_i = 1'b1;
    mem_ack_i = 1'b1;
    #1;
    check("arst_memreq", {127'd0, mem_req_o},    128'd0);
    check("arst_busy",   {127'd0, busy_o},       128'd0);
    check("arst_dack",   {127'd0, dcache_ack_o}, 128'd0);
    tick();
    rst_i = 1'b0; mem_ack_i = 1'b0; dcache_req_i = 1'b0; dcache_wr_i = 1'b0;
    last_d = 0;
    tick();
    icache_req_i = 1'b1; icache_addr_i = I_ADDR;
    @(negedge clk_i);
    check("post_rst_n", {127'd0, mem_req_o}, 128'd0);
    tick();
    @(negedge clk_i);
    check("post_rst_n1", {127'd0, mem_req_o}, 128'd1);
    single(1);

    // Randomized run against the transaction-level model
    m_own = 0; i_cool = 0; d_cool = 0;
    tick();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!i_cool && !icache_req_i && $urandom_range(0, 2) == 0) begin
        icache_req_i = 1'b1; icache_addr_i = $urandom;
      end
      if (!d_cool && !dcache_req_i && $urandom_range(0, 2) == 0) begin
        dcache_req_i = 1'b1; dcache_wr_i = $urandom_range(0, 1) == 1;
        dcache_addr_i = $urandom;
        dcache_wdata_i = {$urandom, $urandom, $urandom, $urandom};
      end
      i_cool = 0; d_cool = 0;
      mem_rdata_i = {$urandom, $urandom, $urandom, $urandom};
      mem_ack_i = (m_own != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);

      @(negedge clk_i);
      e_addr  = (m_own == 1) ? icache_addr_i : (m_own == 2) ? dcache_addr_i : '0;
      e_wdata = (m_own == 2) ? dcache_wdata_i : '0;
      check("rnd_busy",   {127'd0, busy_o},    {127'd0, m_own != 0});
      check("rnd_memreq", {127'd0, mem_req_o}, {127'd0, m_own != 0});
      check("rnd_memwr",  {127'd0, mem_wr_o},  {127'd0, (m_own == 2) && dcache_wr_i});
      check("rnd_addr",   {96'd0, mem_addr_o}, {96'd0, e_addr});
      check("rnd_wdata",  mem_wdata_o, e_wdata);
      check("rnd_iack",   {127'd0, icache_ack_o}, {127'd0, (m_own == 1) && mem_ack_i});
      check("rnd_dack",   {127'd0, dcache_ack_o}, {127'd0, (m_own == 2) && mem_ack_i});
      check("rnd_rdata",  dcache_rdata_o ^ icache_rdata_o ^ mem_rdata_i, mem_rdata_i);

      @(posedge clk_i);
      i_done = (m_own == 1) && mem_ack_i;
      d_done = (m_own == 2) && mem_ack_i;
      if (m_own == 0) begin
`ifdef ARB_ROUND_ROBIN_EN
        tie_own = (last_d != 0) ? 1 : 2;
`else
        tie_own = 2;
`endif
        if (icache_req_i && dcache_req_i) m_own = tie_own;
        else if (icache_req_i)            m_own = 1;
        else if (dcache_req_i)            m_own = 2;
        if (m_own != 0) last_d = (m_own == 2) ? 1 : 0;
      end else if (mem_ack_i) begin
        m_own = 0;
      end
      #1;
      if (i_done) begin icache_req_i = 1'b0; i_cool = 1; end
      if (d_done) begin dcache_req_i = 1'b0; d_cool = 1; end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cache_mem_arbiter
`default_nettype wire
